// File: rtl/riscv_pc_unit.sv
// -----------------------------------------------------------------------------
// riscv_pc_unit
//
// Program-counter sequencer for a small non-pipelined RISC-V core. It offers
// the current PC to instruction fetch. It then waits for the execute stage to
// present the decoded control-flow information for that instruction. Once
// execute hands it over, it commits the next PC.
//
// State table:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_BOOT  | first cycle after reset release; nothing offered to fetch
//   S_FETCH | pc_o offered to fetch (if_valid_o=1), waiting for if_ready_i
//   S_EXEC  | instruction in execute, waiting for ex_valid_i to commit npc_o
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   pc_o            current instruction address
//   if_valid_o      pc_o offered to fetch (S_FETCH only)
//   if_ready_i      fetch accepts pc_o (sampled in S_FETCH only)
//   ex_valid_i      execute inputs valid (sampled in S_EXEC only)
//   branch_op_i     000 seq, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt,
//                   111 bge; 011 behaves as seq
//   unsigned_i      blt/bge compare unsigned
//   rs1_i, rs2_i    compare operands; rs1_i is also the jalr base
//   imm_i           sign-extended immediate
//   trap_i          exception/ecall on the current instruction
//   trap_vec_i      trap target
//   mret_i, epc_i   mret request and its target
//   npc_o           combinational next PC for the current instruction
//   retire_o        one-cycle pulse per committed instruction
//   misalign_o      one-cycle pulse on a misaligned taken target
//   badaddr_o       faulting target, captured together with misalign_o
//   instret_o       retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module riscv_pc_unit #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VEC = 32'h8000_0000,
  parameter int unsigned       CNT_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  pc_o,
  output logic             if_valid_o,
  input  logic             if_ready_i,
  input  logic             ex_valid_i,
  input  logic [2:0]       branch_op_i,
  input  logic             unsigned_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  trap_vec_i,
  input  logic             mret_i,
  input  logic [XLEN-1:0]  epc_i,
  output logic [XLEN-1:0]  npc_o,
  output logic             retire_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  badaddr_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [1:0] S_BOOT  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_EXEC  = 2'b10;

  localparam logic [2:0] OP_JAL  = 3'b001;
  localparam logic [2:0] OP_JALR = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;
  localparam logic [2:0] OP_BLT  = 3'b110;
  localparam logic [2:0] OP_BGE  = 3'b111;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_CLEAR = ~XLEN'(1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            accept;

  logic            rs_eq;
  logic            rs_lt;
  logic            redirect;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] raw_target;
  logic            target_misaligned;
  logic            report_misalign;

  // ---------------------------------------------------------------------------
  // Branch resolution and target selection
  // ---------------------------------------------------------------------------
  assign rs_eq = (rs1_i == rs2_i);
  assign rs_lt = unsigned_i ? (rs1_i < rs2_i)
                            : ($signed(rs1_i) < $signed(rs2_i));

  assign pc_plus4    = pc_o + PC_STEP;
  assign pc_plus_imm = pc_o + imm_i;
  assign jalr_target = (rs1_i + imm_i) & LSB_CLEAR;

  always_comb begin
    redirect = 1'b0;
    case (branch_op_i)
      OP_JAL:  redirect = 1'b1;
      OP_JALR: redirect = 1'b1;
      OP_BEQ:  redirect = rs_eq;
      OP_BNE:  redirect = !rs_eq;
      OP_BLT:  redirect = rs_lt;
      OP_BGE:  redirect = !rs_lt;
      default: redirect = 1'b0;
    endcase
  end

  always_comb begin
    raw_target = pc_plus4;
    if (redirect) begin
      raw_target = (branch_op_i == OP_JALR) ? jalr_target : pc_plus_imm;
    end
  end

  // Only redirected targets are alignment-checked; a fall-through from an
  // odd PC (reachable via mret/trap vectors) is not flagged.
  assign target_misaligned = redirect && (raw_target[1:0] != 2'b00);

  // A trap on the same instruction takes precedence and hides the fault.
  assign report_misalign = target_misaligned && !trap_i;

  always_comb begin
    if (trap_i) begin
      npc_o = trap_vec_i;
    end else if (target_misaligned) begin
      npc_o = trap_vec_i;
    end else if (mret_i) begin
      npc_o = epc_i;
    end else begin
      npc_o = raw_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  assign accept     = (state == S_EXEC) && ex_valid_i;
  assign if_valid_o = (state == S_FETCH);

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: if (if_ready_i) state_nxt = S_EXEC;
      S_EXEC:  if (ex_valid_i) state_nxt = S_FETCH;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BOOT;
      pc_o       <= RESET_VEC;
      retire_o   <= 1'b0;
      misalign_o <= 1'b0;
      badaddr_o  <= '0;
      instret_o  <= '0;
    end else begin
      state      <= state_nxt;
      retire_o   <= accept;
      misalign_o <= accept && report_misalign;
      if (accept) begin
        pc_o      <= npc_o;
        instret_o <= instret_o + CNT_W'(1);
        if (report_misalign) begin
          badaddr_o <= raw_target;
        end
      end
    end
  end

endmodule
